spawn_scheduler: RTL
====================

# spawn_scheduler

Frame-rate spawn controller for the on-screen object slots. Once per video frame it decides whether to spawn a new object. It picks a free slot round-robin and chooses collectable vs hazard subject to a hazard cap. It then offers the spawn command to the game-logic datapath over a valid/ack handshake. Spawn probability and spacing tighten with score-derived level.

## Interface

Parameters:
- NUM_SLOTS, 5, number of object slots (1..8)
- MIN_GAP, 16, base minimum frames between accepted spawns (8..63)
- BASE_THRESH, 2, base spawn roll threshold (0..56)
- MAX_HAZARDS, 3, max hazards on screen before hazards are suppressed
- Y_BASE, 230, base vertical position; Y_BASE+255 must be ≤ 1023
- SCREEN_WIDTH, 1024, horizontal spawn position

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  high while game is in PLAY
- frame_tick  in  1  one-cycle pulse per frame (vsync pulse)
- random  in  32  free-running random word, new value each frame
- slot_busy  in  NUM_SLOTS  bit i = slot i occupied
- slot_hazard  in  NUM_SLOTS  bit i = slot i holds a hazard (valid where busy)
- score  in  10  current score
- spawn_valid  out  1  spawn command offered
- spawn_slot  out  3  target slot index
- spawn_id  out  1  0 = collectable, 1 = hazard
- spawn_hpos  out  11  horizontal position (SCREEN_WIDTH)
- spawn_vpos  out  10  vertical position
- spawn_ack  in  1  datapath accepts command this cycle
- level  out  3  difficulty level
- drop_cnt  out  8  saturating count of spawn rolls lost to full slots

## Operation

- States: IDLE, WAIT, OFFER.
- IDLE: spawn_valid=0. On enable=1, load gap_cnt=MIN_GAP and go to WAIT.
- WAIT, on frame_tick:
  - If gap_cnt≠0, decrement it and do nothing else.
  - If gap_cnt=0, roll: hit iff random[31:26] < BASE_THRESH+level, with the compare 7 bits wide.
  - On hit with a free slot: search from (rr_ptr+1) mod NUM_SLOTS upward, wrapping, for the first i with slot_busy[i]=0.
  - Register spawn_slot=i.
  - Register spawn_id=random[3], forced to 0 when popcount(slot_busy & slot_hazard) ≥ MAX_HAZARDS.
  - Register spawn_vpos=Y_BASE+random[7:0] and spawn_hpos=SCREEN_WIDTH, then go to OFFER.
  - On hit with all slots busy: drop_cnt+=1, saturating at 255; stay in WAIT with gap_cnt=0.
  - On miss: stay in WAIT.
- OFFER: spawn_valid=1. Slot/id/hpos/vpos are held stable. frame_tick is ignored.
  - spawn_ack=1: rr_ptr<=spawn_slot, gap_cnt<=max(MIN_GAP−level,1), go to WAIT.
  - slot_busy[spawn_slot]=1 without ack: withdraw, gap_cnt<=0, go to WAIT. Ack has priority if both occur in the same cycle.
- level = min(score[9:4], 7), registered and updated every cycle.
- enable=0 in any state: go to IDLE next cycle and drop spawn_valid. rr_ptr, level and drop_cnt are retained.
- spawn_ack outside OFFER is ignored.

## Timing

- Reset (reset_n=0 at a clock edge) forces these values; it overrides everything, including mid-OFFER:
  - state=IDLE, spawn_valid=0, spawn_slot=0, spawn_id=0, spawn_hpos=0, spawn_vpos=0
  - level=0, drop_cnt=0, gap_cnt=0, rr_ptr=NUM_SLOTS−1, so the first pick searches from slot 0
- Latency: a frame_tick sampled at edge N produces spawn_valid=1 after edge N. It is visible during cycle N+1.
- Handshake: a transfer occurs on an edge where spawn_valid=1 and spawn_ack=1. spawn_valid is 0 after that edge, so there is at most one transfer per offer.
- Command fields change only on the WAIT→OFFER edge.
- Withdrawal on busy or on enable loss: spawn_valid falls at the next edge.
- At most one spawn per frame_tick. A frame_tick coincident with an ack is ignored.
- Arithmetic: spawn_vpos is 10-bit with no overflow, given the Y_BASE constraint. The gap reload is computed on 6 bits.

## Test plan

1. Reset, then enable=1, random[31:26]=0 constant, all slots free, score=0 → the first spawn_valid follows the 17th frame_tick (16 gap ticks plus the roll). spawn_slot=0, spawn_hpos=1024.
2. Ack the spawn and mark slot 0 busy, repeat with ack each time → slots issued in order 1,2,3,4,0 (wrap). Spawns are spaced 17 frame_ticks apart.
3. score=80 (level 5), random[31:26]=6, BASE_THRESH=2 → roll hits (6<7); the gap reload after ack is 11. With score=0 the same roll misses.
4. slot_busy=5'b11111, random[31:26]=0 → no spawn_valid; drop_cnt increments once per frame_tick and saturates at 255 after 300 ticks.
5. slot_busy=5'b00111, slot_hazard=5'b00111, random[3]=1 → spawn_slot=3, spawn_id=0 (hazards forced off). With slot_hazard=5'b00011 → spawn_id=1. random[7:0]=8'hFF → spawn_vpos=485.
6. During OFFER, hold ack low and set slot_busy[spawn_slot]=1 → spawn_valid falls the next cycle and the next frame_tick re-rolls. Separately, drop reset_n mid-OFFER → all outputs return to their reset values at the next edge.

Source files
------------

// File: rtl/spawn_scheduler.sv
// Per-frame spawn controller: round-robin free-slot pick, hazard cap, level-scaled
// spawn odds and spacing, and a valid/ack command offer to the game datapath.
module spawn_scheduler #(
    parameter int NUM_SLOTS    = 5,
    parameter int MIN_GAP      = 16,
    parameter int BASE_THRESH  = 2,
    parameter int MAX_HAZARDS  = 3,
    parameter int Y_BASE       = 230,
    parameter int SCREEN_WIDTH = 1024
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 frame_tick,
    input  logic [31:0]          random,
    input  logic [NUM_SLOTS-1:0] slot_busy,
    input  logic [NUM_SLOTS-1:0] slot_hazard,
    input  logic [9:0]           score,
    output logic                 spawn_valid,
    output logic [2:0]           spawn_slot,
    output logic                 spawn_id,
    output logic [10:0]          spawn_hpos,
    output logic [9:0]           spawn_vpos,
    input  logic                 spawn_ack,
    output logic [2:0]           level,
    output logic [7:0]           drop_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        OFFER = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_valid;
    logic [2:0]  r_slot;
    logic        r_id;
    logic [10:0] r_hpos;
    logic [9:0]  r_vpos;
    logic [2:0]  r_level;
    logic [7:0]  r_drop;
    logic [5:0]  r_gap;
    logic [2:0]  r_rr_ptr;

    logic [7:0]  w_busy_ext;
    logic [7:0]  w_haz_ext;
    logic [2:0]  w_pick;
    logic        w_found;
    logic [6:0]  w_thresh;
    logic        w_hit;
    logic        w_hz_full;
    logic [5:0]  w_gap_diff;
    logic [5:0]  w_gap_reload;
    logic [2:0]  w_level_next;
    logic [9:0]  w_vpos_next;
    logic        w_slot_taken;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int k = 0; k < 8; k++) begin
            cnt = cnt + {3'd0, v[k]};
        end
        return cnt;
    endfunction

    // Zero-extend slot vectors to 8 bits so any 3-bit slot index is in range.
    always_comb begin
        w_busy_ext = 8'd0;
        w_haz_ext  = 8'd0;
        w_busy_ext[NUM_SLOTS-1:0] = slot_busy;
        w_haz_ext[NUM_SLOTS-1:0]  = slot_hazard;
    end

    // Round-robin search for the first free slot after the last accepted one.
    always_comb begin
        w_pick  = 3'd0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_SLOTS; k++) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % NUM_SLOTS;
            if (!w_found && !w_busy_ext[idx[2:0]]) begin
                w_found = 1'b1;
                w_pick  = idx[2:0];
            end else begin
                w_found = w_found;
            end
        end
    end

    // Roll, hazard cap, gap reload and field arithmetic.
    always_comb begin
        w_thresh     = 7'(BASE_THRESH) + {4'd0, r_level};
        w_hit        = ({1'b0, random[31:26]} < w_thresh);
        w_hz_full    = (popcount8(w_busy_ext & w_haz_ext) >= 4'(MAX_HAZARDS));
        w_gap_diff   = 6'(MIN_GAP) - {3'd0, r_level};
        w_gap_reload = (w_gap_diff == 6'd0) ? 6'd1 : w_gap_diff;
        w_level_next = (score[9:4] > 6'd7) ? 3'd7 : score[6:4];
        w_vpos_next  = 10'(Y_BASE) + {2'd0, random[7:0]};
        w_slot_taken = w_busy_ext[r_slot];
    end

    // Scheduler state machine with registered command outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_valid  <= 1'b0;
            r_slot   <= 3'd0;
            r_id     <= 1'b0;
            r_hpos   <= 11'd0;
            r_vpos   <= 10'd0;
            r_level  <= 3'd0;
            r_drop   <= 8'd0;
            r_gap    <= 6'd0;
            r_rr_ptr <= 3'(NUM_SLOTS - 1);
        end else begin
            r_level <= w_level_next;
            if (!enable) begin
                r_state <= IDLE;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_gap   <= 6'(MIN_GAP);
                        r_state <= WAIT;
                        r_valid <= 1'b0;
                    end
                    WAIT: begin
                        if (frame_tick) begin
                            if (r_gap != 6'd0) begin
                                r_gap <= r_gap - 6'd1;
                            end else if (w_hit && w_found) begin
                                r_slot  <= w_pick;
                                r_id    <= random[3] & ~w_hz_full;
                                r_vpos  <= w_vpos_next;
                                r_hpos  <= 11'(SCREEN_WIDTH);
                                r_valid <= 1'b1;
                                r_state <= OFFER;
                            end else if (w_hit) begin
                                r_drop <= (r_drop == 8'hFF) ? 8'hFF : r_drop + 8'd1;
                            end
                        end
                    end
                    OFFER: begin
                        // Ack wins over a same-cycle slot collision.
                        if (spawn_ack) begin
                            r_rr_ptr <= r_slot;
                            r_gap    <= w_gap_reload;
                            r_valid  <= 1'b0;
                            r_state  <= WAIT;
                        end else if (w_slot_taken) begin
                            r_gap   <= 6'd0;
                            r_valid <= 1'b0;
                            r_state <= WAIT;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign spawn_valid = r_valid;
    assign spawn_slot  = r_slot;
    assign spawn_id    = r_id;
    assign spawn_hpos  = r_hpos;
    assign spawn_vpos  = r_vpos;
    assign level       = r_level;
    assign drop_cnt    = r_drop;

endmodule
